// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: double-flop synchroniser, mid-start-bit
// qualification, mid-bit data sampling and stop-bit framing check.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err,
  output logic [2:0] o_Rx_State
);

  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t     state, state_nx;
  logic       rx_meta, rx_sync;
  logic [7:0] count, count_nx;
  logic [2:0] bit_idx, bit_idx_nx;
  logic [7:0] shift, shift_nx;
  logic [7:0] rx_byte_nx;
  logic       dv_nx, active_nx, frame_err_nx;

  // o_Rx_DV is a valid-only strobe with no ready: the consumer must take
  // o_Rx_Byte in the DV cycle (the byte also holds until the next good one).
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      rx_meta        <= 1'b1;
      rx_sync        <= 1'b1;
      state          <= IDLE;
      count          <= 8'd0;
      bit_idx        <= 3'd0;
      shift          <= 8'd0;
      o_Rx_Byte      <= 8'd0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Active    <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      rx_meta        <= i_Rx_Serial;
      rx_sync        <= rx_meta;
      state          <= state_nx;
      count          <= count_nx;
      bit_idx        <= bit_idx_nx;
      shift          <= shift_nx;
      o_Rx_Byte      <= rx_byte_nx;
      o_Rx_DV        <= dv_nx;
      o_Rx_Active    <= active_nx;
      o_Rx_Frame_Err <= frame_err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    count_nx     = count;
    bit_idx_nx   = bit_idx;
    shift_nx     = shift;
    rx_byte_nx   = o_Rx_Byte;
    dv_nx        = 1'b0;
    frame_err_nx = 1'b0;
    active_nx    = o_Rx_Active;
    case (state)
      IDLE: begin
        count_nx   = 8'd0;
        bit_idx_nx = 3'd0;
        if (!rx_sync) state_nx = START_BIT;
      end
      START_BIT: begin
        if (count == HALF) begin
          count_nx = 8'd0;
          // A line that has gone high again by mid-bit was only a glitch.
          if (!rx_sync) begin
            active_nx = 1'b1;
            state_nx  = DATA_BITS;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          count_nx = count + 8'd1;
        end
      end
      DATA_BITS: begin
        if (count == LAST) begin
          count_nx          = 8'd0;
          shift_nx[bit_idx] = rx_sync;
          if (bit_idx == 3'd7) begin
            bit_idx_nx = 3'd0;
            state_nx   = STOP_BIT;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
          end
        end else begin
          count_nx = count + 8'd1;
        end
      end
      STOP_BIT: begin
        if (count == LAST) begin
          count_nx  = 8'd0;
          active_nx = 1'b0;
          if (rx_sync) begin
            rx_byte_nx = shift;
            dv_nx      = 1'b1;
            state_nx   = CLEANUP;
          end else begin
            frame_err_nx = 1'b1;
            state_nx     = WAIT_IDLE;
          end
        end else begin
          count_nx = count + 8'd1;
        end
      end
      CLEANUP: begin
        count_nx = 8'd0;
        state_nx = IDLE;
      end
      WAIT_IDLE: begin
        // Stay parked while a break or stuck-low line persists.
        count_nx = 8'd0;
        if (rx_sync) state_nx = IDLE;
      end
      default: begin
        count_nx   = 8'd0;
        bit_idx_nx = 3'd0;
        active_nx  = 1'b0;
        state_nx   = IDLE;
      end
    endcase
  end

  assign o_Rx_State = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one DUT at 87 clocks/bit and one at 4 clocks/bit,
// with negedge monitors recording strobes and their edge indices.
module tb_uart_rx;

  logic       i_Clock = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       rx1 = 1'b1;
  logic       rx2 = 1'b1;
  logic       dv1, act1, fe1;
  logic [7:0] byte1;
  logic [2:0] st1;
  logic       dv2, act2, fe2;
  logic [7:0] byte2;
  logic [2:0] st2;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  int dv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int dv_edge = 0, fe_edge = 0, act_rise_edge = 0;
  logic act_seen = 1'b0, act_prev = 1'b0;
  int dv_edges_q[$];
  logic [7:0] dv_bytes_q[$];
  logic [7:0] exp_q[$];
  int dv2_cnt = 0, dv2_edge = 0;
  logic [7:0] dv2_byte = 8'd0;

  uart_rx #(.CLKS_PER_BIT(87)) dut (
    .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_Rx_Serial(rx1),
    .o_Rx_DV(dv1), .o_Rx_Byte(byte1), .o_Rx_Active(act1),
    .o_Rx_Frame_Err(fe1), .o_Rx_State(st1)
  );

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_Rx_Serial(rx2),
    .o_Rx_DV(dv2), .o_Rx_Byte(byte2), .o_Rx_Active(act2),
    .o_Rx_Frame_Err(fe2), .o_Rx_State(st2)
  );

  // clock / reset
  always #5 i_Clock = ~i_Clock;
  always @(posedge i_Clock) edge_cnt <= edge_cnt + 1;

  // monitors
  always @(negedge i_Clock) begin
    if (dv1) begin
      dv_cnt  <= dv_cnt + 1;
      dv_edge <= edge_cnt;
      dv_edges_q.push_back(edge_cnt);
      dv_bytes_q.push_back(byte1);
    end
    if (fe1) begin
      fe_cnt  <= fe_cnt + 1;
      fe_edge <= edge_cnt;
    end
    if (dv1 && fe1) both_cnt <= both_cnt + 1;
    if (act1) act_seen <= 1'b1;
    if (act1 && !act_prev) act_rise_edge <= edge_cnt;
    act_prev <= act1;
    if (dv2) begin
      dv2_cnt  <= dv2_cnt + 1;
      dv2_edge <= edge_cnt;
      dv2_byte <= byte2;
    end
  end

  // driver tasks: start and end on a negedge
  task automatic drive_line(input bit sel, input logic v);
    if (sel) rx2 = v;
    else     rx1 = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic send_byte(input bit sel, input int clks, input logic [7:0] b,
                           input logic stop_val, input int stop_len, output int t0);
    drive_line(sel, 1'b0);
    t0 = edge_cnt + 1;
    idle(clks);
    for (int i = 0; i < 8; i++) begin
      drive_line(sel, b[i]);
      idle(clks);
    end
    drive_line(sel, stop_val);
    idle(stop_len);
  endtask

  task automatic test_reset;
    i_Rst_n = 1'b0;
    idle(5);
    checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL reset_dv got %0b want 0", dv1); end
    checks++; if (byte1 !== 8'h00) begin errors++; $display("FAIL reset_byte got %02h want 00", byte1); end
    checks++; if (act1 !== 1'b0) begin errors++; $display("FAIL reset_active got %0b want 0", act1); end
    checks++; if (fe1 !== 1'b0) begin errors++; $display("FAIL reset_ferr got %0b want 0", fe1); end
    checks++; if (st1 !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", st1); end
    i_Rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_single;
    int t0, dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_byte(1'b0, 87, 8'hA5, 1'b1, 87, t0);
    idle(20);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL single_dv_count got %0d want 1", dv_cnt - dv0); end
    checks++; if (byte1 !== 8'hA5) begin errors++; $display("FAIL single_byte got %02h want a5", byte1); end
    checks++; if (dv_edge - t0 !== 829) begin errors++; $display("FAIL single_dv_edge got %0d want 829", dv_edge - t0); end
    checks++; if (act_rise_edge - t0 !== 46) begin errors++; $display("FAIL single_active_rise got %0d want 46", act_rise_edge - t0); end
    checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL single_ferr got %0d want %0d", fe_cnt, fe0); end
  endtask

  task automatic test_back_to_back;
    int t0, t1, t2;
    dv_edges_q.delete();
    dv_bytes_q.delete();
    exp_q = '{8'h00, 8'hFF, 8'h5A};
    send_byte(1'b0, 87, 8'h00, 1'b1, 87, t0);
    send_byte(1'b0, 87, 8'hFF, 1'b1, 87, t1);
    send_byte(1'b0, 87, 8'h5A, 1'b1, 87, t2);
    idle(50);
    checks++;
    if (dv_bytes_q.size() !== 3) begin
      errors++; $display("FAIL b2b_count got %0d want 3", dv_bytes_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dv_bytes_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b_byte%0d got %02h want %02h", i, dv_bytes_q[i], exp_q[i]);
        end
      end
      checks++; if (dv_edges_q[0] - t0 !== 829) begin errors++; $display("FAIL b2b_first_edge got %0d want 829", dv_edges_q[0] - t0); end
      checks++; if (dv_edges_q[1] - dv_edges_q[0] !== 870) begin errors++; $display("FAIL b2b_gap01 got %0d want 870", dv_edges_q[1] - dv_edges_q[0]); end
      checks++; if (dv_edges_q[2] - dv_edges_q[1] !== 870) begin errors++; $display("FAIL b2b_gap12 got %0d want 870", dv_edges_q[2] - dv_edges_q[1]); end
    end
  endtask

  task automatic test_glitch;
    int t0, dv0;
    dv0 = dv_cnt;
    act_seen = 1'b0;
    drive_line(1'b0, 1'b0);
    idle(20);
    drive_line(1'b0, 1'b1);
    idle(100);
    checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL glitch_dv got %0d want %0d", dv_cnt, dv0); end
    checks++; if (act_seen !== 1'b0) begin errors++; $display("FAIL glitch_active got %0b want 0", act_seen); end
    checks++; if (st1 !== 3'd0) begin errors++; $display("FAIL glitch_state got %0d want 0", st1); end
    send_byte(1'b0, 87, 8'h3C, 1'b1, 87, t0);
    idle(20);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL glitch_next_count got %0d want 1", dv_cnt - dv0); end
    checks++; if (byte1 !== 8'h3C) begin errors++; $display("FAIL glitch_next_byte got %02h want 3c", byte1); end
  endtask

  task automatic test_frame_err;
    int t0, dv0, fe0;
    send_byte(1'b0, 87, 8'h11, 1'b1, 87, t0);
    idle(20);
    checks++; if (byte1 !== 8'h11) begin errors++; $display("FAIL ferr_pre_byte got %02h want 11", byte1); end
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_byte(1'b0, 87, 8'hC3, 1'b0, 300, t0);
    checks++; if (st1 !== 3'd5) begin errors++; $display("FAIL ferr_wait_state got %0d want 5", st1); end
    drive_line(1'b0, 1'b1);
    idle(87);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", fe_cnt - fe0); end
    checks++; if (fe_edge - t0 !== 829) begin errors++; $display("FAIL ferr_edge got %0d want 829", fe_edge - t0); end
    checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL ferr_dv got %0d want %0d", dv_cnt, dv0); end
    checks++; if (byte1 !== 8'h11) begin errors++; $display("FAIL ferr_hold_byte got %02h want 11", byte1); end
    send_byte(1'b0, 87, 8'h7E, 1'b1, 87, t0);
    idle(20);
    checks++; if (byte1 !== 8'h7E) begin errors++; $display("FAIL ferr_next_byte got %02h want 7e", byte1); end
  endtask

  task automatic test_mid_reset;
    int t0, dv0;
    logic [7:0] b;
    b = 8'h96;
    dv0 = dv_cnt;
    drive_line(1'b0, 1'b0);
    idle(87);
    for (int i = 0; i < 4; i++) begin
      drive_line(1'b0, b[i]);
      idle(87);
    end
    drive_line(1'b0, b[4]);
    idle(40);
    i_Rst_n = 1'b0;
    idle(1);
    i_Rst_n = 1'b1;
    checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL mrst_dv got %0b want 0", dv1); end
    checks++; if (byte1 !== 8'h00) begin errors++; $display("FAIL mrst_byte got %02h want 00", byte1); end
    checks++; if (act1 !== 1'b0) begin errors++; $display("FAIL mrst_active got %0b want 0", act1); end
    checks++; if (st1 !== 3'd0) begin errors++; $display("FAIL mrst_state got %0d want 0", st1); end
    drive_line(1'b0, 1'b1);
    idle(870);
    checks++; if (dv_cnt !== dv0) begin errors++; $display("FAIL mrst_no_strobe got %0d want %0d", dv_cnt, dv0); end
    send_byte(1'b0, 87, 8'h42, 1'b1, 87, t0);
    idle(20);
    checks++; if (byte1 !== 8'h42) begin errors++; $display("FAIL mrst_next_byte got %02h want 42", byte1); end
  endtask

  task automatic test_small_clks;
    int t0, dv0;
    dv0 = dv2_cnt;
    send_byte(1'b1, 4, 8'h81, 1'b1, 4, t0);
    idle(10);
    checks++; if (dv2_cnt - dv0 !== 1) begin errors++; $display("FAIL c4_count got %0d want 1", dv2_cnt - dv0); end
    checks++; if (dv2_byte !== 8'h81) begin errors++; $display("FAIL c4_byte got %02h want 81", dv2_byte); end
    checks++; if (dv2_edge - t0 !== 40) begin errors++; $display("FAIL c4_edge got %0d want 40", dv2_edge - t0); end
  endtask

  task automatic test_exclusive;
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL dv_ferr_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    @(negedge i_Clock);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_mid_reset();
    test_small_clks();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
